// File: rtl/mem_arbiter_pkg.sv
// Shared types for the c_mem arbiter: FSM states, grant encoding and lane-mask helper.
package mem_arbiter_pkg;

    localparam int unsigned MASK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_LS = 1'b1
    } grant_t;

    // Byte lanes only matter for writes; reads always present an all-zero mask.
    function automatic logic [MASK_W-1:0] issue_mask(input logic we, input logic [MASK_W-1:0] mask);
        return we ? mask : '0;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, on a tie the one not granted last wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    output grant_t     grant,
    output logic       any
);

    always_comb begin
        any   = |req;
        grant = GNT_IF;
        if (req == 2'b11) begin
            grant = (last_grant == GNT_IF) ? GNT_LS : GNT_IF;
        end else if (req[1]) begin
            grant = GNT_LS;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch vs load/store arbiter for the single-port c_mem: one transaction at a time,
// registered memory request, read wait with timeout, one-cycle ack to the winner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [MASK_W-1:0] ls_mask,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,

    output logic              mem_request,
    output logic              mem_we_re,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_w_data,
    output logic [MASK_W-1:0] mem_masking,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_r_data
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t            state, state_nxt;
    grant_t            last_grant, last_grant_nxt;
    grant_t            arb_grant;
    logic              arb_any;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              timeout_hit_c;

    logic              if_ack_nxt, if_err_nxt, ls_ack_nxt, ls_err_nxt;
    logic [DATA_W-1:0] if_rdata_nxt, ls_rdata_nxt;
    logic              mem_request_nxt, mem_we_re_nxt;
    logic [ADDR_W-1:0] mem_address_nxt;
    logic [DATA_W-1:0] mem_w_data_nxt;
    logic [MASK_W-1:0] mem_masking_nxt;

    rr_arb2 u_rr_arb2 (
        .req        ({ls_req, if_req}),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .any        (arb_any)
    );

    assign timeout_hit_c = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (arb_any) state_nxt = ST_ISSUE;
            ST_ISSUE:   state_nxt = mem_we_re ? ST_RESP : ST_WAIT_RD;
            ST_WAIT_RD: if (mem_valid || timeout_hit_c) state_nxt = ST_RESP;
            ST_RESP:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Next values of every registered output; memory fields and rdata hold unless updated.
    always_comb begin
        last_grant_nxt  = last_grant;
        cnt_nxt         = cnt;
        if_ack_nxt      = 1'b0;
        if_err_nxt      = 1'b0;
        ls_ack_nxt      = 1'b0;
        ls_err_nxt      = 1'b0;
        if_rdata_nxt    = if_rdata;
        ls_rdata_nxt    = ls_rdata;
        mem_request_nxt = 1'b0;
        mem_we_re_nxt   = mem_we_re;
        mem_address_nxt = mem_address;
        mem_w_data_nxt  = mem_w_data;
        mem_masking_nxt = mem_masking;

        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    last_grant_nxt  = arb_grant;
                    cnt_nxt         = '0;
                    mem_request_nxt = 1'b1;
                    if (arb_grant == GNT_LS) begin
                        mem_we_re_nxt   = ls_we;
                        mem_address_nxt = ls_addr;
                        mem_w_data_nxt  = ls_wdata;
                        mem_masking_nxt = issue_mask(ls_we, ls_mask);
                    end else begin
                        mem_we_re_nxt   = 1'b0;
                        mem_address_nxt = if_addr;
                        mem_w_data_nxt  = '0;
                        mem_masking_nxt = '0;
                    end
                end
            end
            ST_ISSUE: begin
                // A write commits at the close of ISSUE, so it is acked right away.
                if (mem_we_re) ls_ack_nxt = 1'b1;
            end
            ST_WAIT_RD: begin
                if (mem_valid || timeout_hit_c) begin
                    if (last_grant == GNT_LS) begin
                        ls_ack_nxt   = 1'b1;
                        ls_err_nxt   = ~mem_valid;
                        ls_rdata_nxt = mem_valid ? mem_r_data : '0;
                    end else begin
                        if_ack_nxt   = 1'b1;
                        if_err_nxt   = ~mem_valid;
                        if_rdata_nxt = mem_valid ? mem_r_data : '0;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= GNT_LS;
            cnt         <= '0;
            if_ack      <= 1'b0;
            if_err      <= 1'b0;
            if_rdata    <= '0;
            ls_ack      <= 1'b0;
            ls_err      <= 1'b0;
            ls_rdata    <= '0;
            mem_request <= 1'b0;
            mem_we_re   <= 1'b0;
            mem_address <= '0;
            mem_w_data  <= '0;
            mem_masking <= '0;
        end else begin
            last_grant  <= last_grant_nxt;
            cnt         <= cnt_nxt;
            if_ack      <= if_ack_nxt;
            if_err      <= if_err_nxt;
            if_rdata    <= if_rdata_nxt;
            ls_ack      <= ls_ack_nxt;
            ls_err      <= ls_err_nxt;
            ls_rdata    <= ls_rdata_nxt;
            mem_request <= mem_request_nxt;
            mem_we_re   <= mem_we_re_nxt;
            mem_address <= mem_address_nxt;
            mem_w_data  <= mem_w_data_nxt;
            mem_masking <= mem_masking_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural c_mem whose read latency can be stretched or disabled.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ack, if_err;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we, ls_ack, ls_err;
    logic [7:0]  ls_addr;
    logic [31:0] ls_wdata, ls_rdata;
    logic [3:0]  ls_mask;
    logic        mem_request, mem_we_re, mem_valid;
    logic [7:0]  mem_address;
    logic [31:0] mem_w_data, mem_r_data;
    logic [3:0]  mem_masking;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;
    bit overlap  = 1'b0;

    mem_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_mask(ls_mask),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_address(mem_address),
        .mem_w_data(mem_w_data), .mem_masking(mem_masking),
        .mem_valid(mem_valid), .mem_r_data(mem_r_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: unwritten words read as a fixed pattern; read data appears lat cycles after sampling.
    logic [31:0] mem [256];
    bit          wr_seen [256];
    logic [1:0]  pend = 2'd0;
    logic [31:0] rd_q = '0;
    int          req_cnt = 0;
    logic        last_we = 1'b0;
    logic [7:0]  last_addr = '0;
    logic [3:0]  last_mask = '0;
    logic [31:0] last_wdata = '0;

    function automatic logic [31:0] init_word(input logic [7:0] a);
        if (a == 8'h10) return 32'h00500093;
        if (a == 8'h20) return 32'h0;
        return {a, ~a, a, 8'h5A};
    endfunction

    assign mem_valid  = (pend == 2'd1);
    assign mem_r_data = rd_q;

    always @(posedge clk) begin
        logic [31:0] cur;
        cur = wr_seen[mem_address] ? mem[mem_address] : init_word(mem_address);
        if (mem_request) begin
            req_cnt    <= req_cnt + 1;
            last_we    <= mem_we_re;
            last_addr  <= mem_address;
            last_mask  <= mem_masking;
            last_wdata <= mem_w_data;
            if (mem_we_re) begin
                for (int b = 0; b < 4; b++)
                    if (mem_masking[b]) cur[8*b +: 8] = mem_w_data[8*b +: 8];
                mem[mem_address]     <= cur;
                wr_seen[mem_address] <= 1'b1;
            end else begin
                pend <= 2'(lat);
                rd_q <= cur;
            end
        end else if (pend != 2'd0) begin
            pend <= pend - 2'd1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (if_ack && ls_ack) overlap = 1'b1;
    endtask

    // Tick until the selected ack appears; returns cycles from request to ack.
    task automatic wait_ack(input string tag, input bit sel, output int n);
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            seen = sel ? ls_ack : if_ack;
        end
        check({tag, "_ack_seen"}, 64'(seen), 64'd1);
    endtask

    int n;
    int t_prev;
    int acks;
    bit which;
    int rc0;

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_mask = '0;
        repeat (3) tick();
        check("rst_ctl", 64'({if_ack, if_err, ls_ack, ls_err, mem_request, mem_we_re, mem_masking}), 64'd0);
        check("rst_addr", 64'(mem_address), 64'd0);
        check("rst_data", 64'({if_rdata, ls_rdata}), 64'd0);
        check("rst_wdata", 64'(mem_w_data), 64'd0);
        rst = 1'b0;
        tick();

        // 1: single fetch
        if_addr = 8'h10; if_req = 1'b1;
        tick();
        check("t1_issue_req", 64'(mem_request), 64'd1);
        check("t1_issue_we", 64'(mem_we_re), 64'd0);
        wait_ack("t1", 1'b0, n);
        n += 1;
        if_req = 1'b0;
        check("t1_latency", 64'(n), 64'd3);
        check("t1_rdata", 64'(if_rdata), 64'h00500093);
        check("t1_err", 64'(if_err), 64'd0);
        check("t1_ls_ack", 64'(ls_ack), 64'd0);
        check("t1_addr", 64'({last_we, last_mask, last_addr}), 64'h0_0_10);
        tick();
        check("t1_ack_pulse", 64'(if_ack), 64'd0);

        // 2: masked write then readback
        rc0 = req_cnt;
        ls_we = 1'b1; ls_addr = 8'h20; ls_wdata = 32'hDEADBEEF; ls_mask = 4'b0011; ls_req = 1'b1;
        wait_ack("t2w", 1'b1, n);
        ls_req = 1'b0;
        check("t2_latency", 64'(n), 64'd2);
        check("t2_one_request", 64'(req_cnt - rc0), 64'd1);
        check("t2_fields", 64'({last_we, last_mask, last_addr}), 64'h1_3_20);
        check("t2_wdata", 64'(last_wdata), 64'hDEADBEEF);
        tick();
        ls_we = 1'b0; ls_mask = 4'hF; ls_req = 1'b1;
        wait_ack("t2r", 1'b1, n);
        ls_req = 1'b0;
        check("t2_read_latency", 64'(n), 64'd3);
        check("t2_readback", 64'(ls_rdata), 64'h0000BEEF);
        check("t2_read_mask", 64'({last_we, last_mask}), 64'd0);
        tick();

        // 3: contention from reset alternates IF, LS, IF, LS
        rst = 1'b1;
        if_addr = 8'h03; if_req = 1'b1;
        ls_addr = 8'h04; ls_we = 1'b0; ls_req = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(if_ack || ls_ack) && n < 20) begin
                tick();
                n++;
            end
            which = ls_ack;
            check("t3_grant_order", 64'({if_ack, ls_ack}), (k % 2 == 1) ? 64'b01 : 64'b10);
            check("t3_rdata", 64'(which ? ls_rdata : if_rdata), which ? 64'h04FB045A : 64'h03FC035A);
            if (k == 3) begin
                if_req = 1'b0;
                ls_req = 1'b0;
            end
            tick();
        end

        // 4: read timeout, then a normal read
        lat = 0;
        ls_addr = 8'h05; ls_req = 1'b1;
        wait_ack("t4", 1'b1, n);
        ls_req = 1'b0;
        check("t4_latency", 64'(n), 64'd6);
        check("t4_err", 64'(ls_err), 64'd1);
        check("t4_rdata", 64'(ls_rdata), 64'd0);
        tick();
        check("t4_err_pulse", 64'({ls_ack, ls_err}), 64'd0);
        lat = 1;
        ls_addr = 8'h04; ls_req = 1'b1;
        wait_ack("t4b", 1'b1, n);
        ls_req = 1'b0;
        check("t4b_latency", 64'(n), 64'd3);
        check("t4b_err", 64'(ls_err), 64'd0);
        check("t4b_rdata", 64'(ls_rdata), 64'h04FB045A);
        tick();

        // 5: reset during WAIT_RD with a late mem_valid still pending
        lat = 3;
        if_addr = 8'h06; if_req = 1'b1;
        tick();
        check("t5_issue", 64'(mem_request), 64'd1);
        tick();
        check("t5_wait_req", 64'(mem_request), 64'd0);
        rst = 1'b1; if_req = 1'b0;
        tick();
        check("t5_outs_zero", 64'({if_ack, if_err, ls_ack, ls_err, mem_request, mem_we_re, mem_masking, mem_address}), 64'd0);
        rst = 1'b0;
        acks = 0;
        repeat (4) begin
            tick();
            if (if_ack || ls_ack) acks++;
        end
        check("t5_no_ack", 64'(acks), 64'd0);
        lat = 1;
        if_addr = 8'h07; if_req = 1'b1;
        wait_ack("t5b", 1'b0, n);
        if_req = 1'b0;
        check("t5b_latency", 64'(n), 64'd3);
        check("t5b_rdata", 64'(if_rdata), 64'h07F8075A);
        tick();

        // 6: back-to-back fetches, re-raised the cycle after each ack
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            if_addr = 8'(k); if_req = 1'b1;
            wait_ack("t6", 1'b0, n);
            if_req = 1'b0;
            check("t6_rdata", 64'(if_rdata), 64'({8'(k), ~8'(k), 8'(k), 8'h5A}));
            if (k > 0) check("t6_spacing", 64'(cyc - t_prev), 64'd4);
            t_prev = cyc;
            tick();
        end

        check("no_ack_overlap", 64'(overlap), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
